pool_window_addr_gen: RTL

Parametrised read-address generator for 2x2, stride-2 pooling over one or more stacked feature maps held in a single linear buffer. It walks every pooling window and presents the four addresses of each window on one valid/ready beat. A pooling datapath consumes the beat and reads a dual- or quad-ported feature-map RAM. The generator supports arbitrary even map sizes, multiple channels, a base offset, and back-pressure, and it raises a completion pulse when the walk finishes.

---
 rtl/pool_window_addr_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pool_window_addr_gen.sv
// 2x2 stride-2 pooling window address walker over stacked feature maps.
// Emits the four window addresses per valid/ready beat, pulses done at end.
module pool_window_addr_gen #(
  parameter  int MAP_W     = 8,
  parameter  int MAP_H     = 8,
  parameter  int CHANNELS  = 1,
  parameter  int ADDR_W    = 6,
  parameter  int BASE_ADDR = 0,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [CH_W-1:0]   chan,
  output logic              last_win,
  output logic              busy,
  output logic              done
);

  localparam int COLS = MAP_W / 2;
  localparam int ROWS = MAP_H / 2;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(BASE_ADDR + 1);
  localparam logic [ADDR_W-1:0] A2 = ADDR_W'(BASE_ADDR + MAP_W);
  localparam logic [ADDR_W-1:0] A3 = ADDR_W'(BASE_ADDR + MAP_W + 1);
  localparam logic [ADDR_W-1:0] STEP_K = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] STEP_R = ADDR_W'(MAP_W + 2);

  localparam logic [CW-1:0]   C_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0]   R_MAX  = RW'(ROWS - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_a0, r_a1, r_a2, r_a3;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CH_W-1:0]   r_chan;
  logic              r_valid, r_last, r_busy, r_done;

  logic              w_col_end, w_row_end, w_chan_end, w_final, w_accept;
  logic [ADDR_W-1:0] w_step;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;
  logic [CH_W-1:0]   w_chan_nxt;
  logic              w_last_nxt;

  assign w_col_end  = (r_col == C_MAX);
  assign w_row_end  = (r_row == R_MAX);
  assign w_chan_end = (r_chan == CH_MAX);
  assign w_final    = w_col_end && w_row_end && w_chan_end;
  assign w_accept   = r_valid && out_ready;

  // End of a window row skips the odd row; this also lands on the next channel.
  assign w_step     = w_col_end ? STEP_R : STEP_K;
  assign w_col_nxt  = w_col_end ? '0 : r_col + CW'(1);
  assign w_row_nxt  = !w_col_end ? r_row :
                      (w_row_end ? '0 : r_row + RW'(1));
  assign w_chan_nxt = !(w_col_end && w_row_end) ? r_chan :
                      (w_chan_end ? '0 : r_chan + CH_W'(1));
  assign w_last_nxt = (w_col_nxt == C_MAX) && (w_row_nxt == R_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a0    <= A0;
      r_a1    <= A1;
      r_a2    <= A2;
      r_a3    <= A3;
      r_col   <= '0;
      r_row   <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (COLS == 1) && (ROWS == 1);
          end
        end
        S_RUN: begin
          if (w_accept && w_final) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_a0    <= A0;
            r_a1    <= A1;
            r_a2    <= A2;
            r_a3    <= A3;
            r_col   <= '0;
            r_row   <= '0;
            r_chan  <= '0;
          end else if (w_accept) begin
            r_a0    <= r_a0 + w_step;
            r_a1    <= r_a1 + w_step;
            r_a2    <= r_a2 + w_step;
            r_a3    <= r_a3 + w_step;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_chan  <= w_chan_nxt;
            r_last  <= w_last_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign addr0     = r_a0;
  assign addr1     = r_a1;
  assign addr2     = r_a2;
  assign addr3     = r_a3;
  assign chan      = r_chan;
  assign last_win  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
